// File: rtl/idex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// idex_stage_reg_pkg
//   Shared definitions for the ID/EX pipeline register slice.
//   Contents:
//     ALU_OP_WIDTH  default width of the ALU operation code
//     REG_IDX_W     register index width (32 architectural registers)
//     REG_ZERO      index of the hard-wired zero register x0
//     aluOpE        ALU operation encodings used by decode and EX
//     updSelE       which update the ID/EX register performs on the next edge
//     selIsBubble() true for update kinds that squash the slot
// ---------------------------------------------------------------------------
package idex_stage_reg_pkg;

  localparam int ALU_OP_WIDTH = 4;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // ALU operation encodings shared between decode and the EX-stage ALU.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } aluOpE;

  // Kind of update applied to the ID/EX register at the next rising edge,
  // listed in decreasing priority.
  typedef enum logic [2:0] {
    UPD_RESET   = 3'd0,
    UPD_FLUSH   = 3'd1,
    UPD_HOLD    = 3'd2,
    UPD_LOADUSE = 3'd3,
    UPD_IDLE    = 3'd4,
    UPD_LOAD    = 3'd5
  } updSelE;

  // A flushed slot, a load-use bubble and an empty decode slot all load a
  // bubble: controls and register indices are forced to zero.
  function automatic logic selIsBubble(input updSelE sel);
    logic isBubble;
    isBubble = 1'b0;
    case (sel)
      UPD_FLUSH,
      UPD_LOADUSE,
      UPD_IDLE:  isBubble = 1'b1;
      default:   isBubble = 1'b0;
    endcase
    return isBubble;
  endfunction

endpackage

// File: rtl/idex_stage_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard detector. Flags the case where the
//   instruction in EX is a load whose destination is read by the
//   instruction currently in decode, so its data cannot be forwarded in time.
//   Ports:
//     idValid    in   decode holds a real instruction
//     idRs1      in   decode source index 1
//     idRs2      in   decode source index 2
//     idUsesRs1  in   decode instruction actually reads rs1
//     idUsesRs2  in   decode instruction actually reads rs2
//     idexValid  in   EX slot holds a real instruction
//     idexMemrd  in   EX instruction is a load
//     idexRd     in   EX destination index
//     loadUse    out  hazard present
// ---------------------------------------------------------------------------
module load_use_detect
  import idex_stage_reg_pkg::*;
(
  input  logic                 idValid,
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUsesRs1,
  input  logic                 idUsesRs2,
  input  logic                 idexValid,
  input  logic                 idexMemrd,
  input  logic [REG_IDX_W-1:0] idexRd,
  output logic                 loadUse
);

  logic loadInEx;
  logic rs1Hit;
  logic rs2Hit;

  // A load targeting x0 produces nothing anyone can consume, so it never
  // counts as a hazard source. Only sources the instruction really reads are
  // compared, so immediates that happen to alias a register field are ignored.
  always_comb begin
    loadInEx = idexValid & idexMemrd & (idexRd != REG_ZERO);
    rs1Hit   = idUsesRs1 & (idRs1 == idexRd);
    rs2Hit   = idUsesRs2 & (idRs2 == idexRd);
    loadUse  = idValid & loadInEx & (rs1Hit | rs2Hit);
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ---------------------------------------------------------------------------
// idex_stage_reg
//   ID/EX pipeline register with load-use hazard detection, bubble insertion
//   and branch flush. Also counts inserted load-use bubbles.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     id_*                 decoded instruction fields from the ID stage
//     ex_flush             taken branch/jump resolved in EX this cycle
//     hold                 global freeze
//     idex_*               registered copies of the ID fields plus idex_valid
//     stall                freeze PC and IF/ID this cycle (combinational)
//     perf_stall_cnt       saturating count of load-use bubbles since reset
//   Update priority per edge: reset, flush, hold, load-use, normal load.
//   Invariant: idex_valid=0 implies regwr/memrd/memwr/memtoreg/branch=0 and
//   rd/rs1/rs2=0, so forwarding and write-back never match a squashed slot.
// ---------------------------------------------------------------------------
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = ALU_OP_WIDTH,
  parameter int PERF_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic                 id_regwr,
  input  logic                 id_memrd,
  input  logic                 id_memwr,
  input  logic                 id_memtoreg,
  input  logic                 id_alusrc,
  input  logic                 id_branch,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic                 ex_flush,
  input  logic                 hold,
  output logic                 idex_valid,
  output logic [XLEN-1:0]      idex_pc,
  output logic [REG_IDX_W-1:0] idex_rs1,
  output logic [REG_IDX_W-1:0] idex_rs2,
  output logic [REG_IDX_W-1:0] idex_rd,
  output logic [XLEN-1:0]      idex_rs1_data,
  output logic [XLEN-1:0]      idex_rs2_data,
  output logic [XLEN-1:0]      idex_imm,
  output logic                 idex_regwr,
  output logic                 idex_memrd,
  output logic                 idex_memwr,
  output logic                 idex_memtoreg,
  output logic                 idex_alusrc,
  output logic                 idex_branch,
  output logic [ALUOP_W-1:0]   idex_aluop,
  output logic                 stall,
  output logic [PERF_W-1:0]    perf_stall_cnt
);

  logic   loadUse;
  updSelE updSel;
  logic   bubble;

  load_use_detect uLoadUseDetect (
    .idValid   (id_valid),
    .idRs1     (id_rs1),
    .idRs2     (id_rs2),
    .idUsesRs1 (id_uses_rs1),
    .idUsesRs2 (id_uses_rs2),
    .idexValid (idex_valid),
    .idexMemrd (idex_memrd),
    .idexRd    (idex_rd),
    .loadUse   (loadUse)
  );

  // The front end only needs to freeze when this register actually inserts a
  // load-use bubble. A flush discards the decode instruction anyway, and a
  // global hold already freezes everything.
  assign stall = loadUse & ~ex_flush & ~hold & ~rst;

  // Pick the single update kind for the coming edge in priority order.
  always_comb begin
    updSel = UPD_LOAD;
    if (rst) begin
      updSel = UPD_RESET;
    end else if (ex_flush) begin
      updSel = UPD_FLUSH;
    end else if (hold) begin
      updSel = UPD_HOLD;
    end else if (loadUse) begin
      updSel = UPD_LOADUSE;
    end else if (!id_valid) begin
      updSel = UPD_IDLE;
    end
  end

  assign bubble = selIsBubble(updSel);

  // Pipeline register. Data-only fields (pc, operands, immediate, aluop,
  // alusrc) are loaded on every non-hold edge, even for bubbles, since they
  // are meaningless once idex_valid is low; only the fields that can cause
  // side effects or forwarding matches are forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid    <= 1'b0;
      idex_pc       <= '0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rd       <= '0;
      idex_rs1_data <= '0;
      idex_rs2_data <= '0;
      idex_imm      <= '0;
      idex_regwr    <= 1'b0;
      idex_memrd    <= 1'b0;
      idex_memwr    <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_branch   <= 1'b0;
      idex_aluop    <= '0;
    end else if (updSel != UPD_HOLD) begin
      idex_pc       <= id_pc;
      idex_rs1_data <= id_rs1_data;
      idex_rs2_data <= id_rs2_data;
      idex_imm      <= id_imm;
      idex_alusrc   <= id_alusrc;
      idex_aluop    <= id_aluop;
      if (bubble) begin
        idex_valid    <= 1'b0;
        idex_rs1      <= REG_ZERO;
        idex_rs2      <= REG_ZERO;
        idex_rd       <= REG_ZERO;
        idex_regwr    <= 1'b0;
        idex_memrd    <= 1'b0;
        idex_memwr    <= 1'b0;
        idex_memtoreg <= 1'b0;
        idex_branch   <= 1'b0;
      end else begin
        idex_valid    <= 1'b1;
        idex_rs1      <= id_rs1;
        idex_rs2      <= id_rs2;
        idex_rd       <= id_rd;
        idex_regwr    <= id_regwr;
        idex_memrd    <= id_memrd;
        idex_memwr    <= id_memwr;
        idex_memtoreg <= id_memtoreg;
        idex_branch   <= id_branch;
      end
    end
  end

  // Count only real load-use bubbles; flush and idle bubbles are not stalls.
  // The counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (updSel == UPD_LOADUSE && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end

endmodule
